// File: rtl/hub75_capture.sv
// ============================================================================
// Module      : hub75_capture
// Description : HUB75 receive side. Samples the serial panel link (colour
//               bits, shift clock, latch strobe, row address), rebuilds
//               COLOR_DEPTH-bit pixels from the bit-planes and flushes each
//               completed row into a framebuffer through the ctrl_* port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: HUB75_CAPTURE_STATS_EN
//   When defined, adds stat_rows (rows flushed) and stat_errs (error events).
// ----------------------------------------------------------------------------
// Ports:
//   ctrl_clk                  system clock (>= 3x hub_clk toggle rate)
//   resetn                    asynchronous active-low reset
//   hub_r0/g0/b0, hub_r1/g1/b1  colour bits, top / bottom half
//   hub_a..hub_e              row address, hub_a is LSB
//   hub_clk, hub_stb          shift clock / latch strobe (rising edge)
//   ctrl_ready                framebuffer accepts a write this cycle
//   err_clr                   clears the sticky error flags
//   ctrl_en, ctrl_wr          write valid / channel write enables
//   ctrl_addr                 {row[5:0], x}, zero-extended to 16 bits
//   ctrl_wdat                 {R8, G8, B8}
//   err_sync, err_overrun     sticky error flags
//   stat_rows, stat_errs      statistics (HUB75_CAPTURE_STATS_EN only)
// ============================================================================
`default_nettype none

module hub75_capture #(
  parameter int COLOR_DEPTH = 7,
  parameter int CHAINED     = 1
) (
  input  logic        ctrl_clk,
  input  logic        resetn,
  input  logic        hub_r0,
  input  logic        hub_g0,
  input  logic        hub_b0,
  input  logic        hub_r1,
  input  logic        hub_g1,
  input  logic        hub_b1,
  input  logic        hub_a,
  input  logic        hub_b,
  input  logic        hub_c,
  input  logic        hub_d,
  input  logic        hub_e,
  input  logic        hub_clk,
  input  logic        hub_stb,
  input  logic        ctrl_ready,
  input  logic        err_clr,
  output logic        ctrl_en,
  output logic [3:0]  ctrl_wr,
  output logic [15:0] ctrl_addr,
  output logic [23:0] ctrl_wdat,
  output logic        err_sync,
  output logic        err_overrun
`ifdef HUB75_CAPTURE_STATS_EN
  ,
  output logic [15:0] stat_rows,
  output logic [15:0] stat_errs
`endif
);

  localparam int c_N  = 64 * CHAINED;
  localparam int c_XW = 6 + $clog2(CHAINED);
  localparam int c_CW = c_XW + 1;   // column counter must hold N
  localparam int c_IW = c_XW + 2;   // beat counter must hold 2N
  localparam int c_PW = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
  localparam logic [c_CW-1:0] c_NCOL  = c_CW'(c_N);
  localparam logic [c_IW-1:0] c_BEATS = c_IW'(2 * c_N);
  localparam logic [c_PW-1:0] c_LASTP = c_PW'(COLOR_DEPTH - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  // ---------------- input synchroniser ----------------
  // bits: [5:0] r0 g0 b0 r1 g1 b1, [10:6] row {e,d,c,b,a}, [11] clk, [12] stb
  logic [12:0] w_hub_raw;
  logic [12:0] r_sync1, r_sync2;
  logic [1:0]  r_prev;

  assign w_hub_raw = {hub_stb, hub_clk, hub_e, hub_d, hub_c, hub_b, hub_a,
                      hub_b1, hub_g1, hub_r1, hub_b0, hub_g0, hub_r0};

  always_ff @(posedge ctrl_clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_hub_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2[12:11];
    end
  end

  logic       w_clk_rise, w_stb_rise;
  logic [4:0] w_row;
  assign w_clk_rise = r_sync2[11] & ~r_prev[0];
  assign w_stb_rise = r_sync2[12] & ~r_prev[1];
  assign w_row      = r_sync2[10:6];

  // ---------------- capture control ----------------
  state_t            r_state, w_state_nxt;
  logic [c_CW-1:0]   r_col, w_col_after;
  logic [c_PW-1:0]   r_plane, w_commit_plane;
  logic [4:0]        r_last_row;
  logic              r_cap_bank;
  logic              w_col_full, w_clk_wr, w_clk_err;
  logic              w_stb_bad, w_stb_ok, w_row_jump, w_row_done;
  logic              w_handoff, w_overrun;

  always_comb begin
    w_col_full     = (r_col == c_NCOL);
    w_clk_wr       = w_clk_rise & ~w_col_full;
    w_clk_err      = w_clk_rise & w_col_full;
    // the shift edge is applied before a coincident strobe is judged
    w_col_after    = w_clk_wr ? (r_col + c_CW'(1)) : r_col;
    w_stb_bad      = w_stb_rise & (w_col_after != c_NCOL);
    w_stb_ok       = w_stb_rise & ~w_stb_bad;
    w_row_jump     = w_stb_ok & (w_row != r_last_row) & (r_plane != '0);
    w_row_done     = w_stb_ok & ~w_row_jump & (r_plane == c_LASTP);
    w_handoff      = w_row_done & (r_state == S_IDLE);
    w_overrun      = w_row_done & (r_state != S_IDLE);
    // a row jump re-interprets the just-shifted line as plane 0 of the new row
    w_commit_plane = w_row_jump ? '0 : r_plane;
  end

  always_ff @(posedge ctrl_clk or negedge resetn) begin
    if (!resetn) begin
      r_col       <= '0;
      r_plane     <= '0;
      r_last_row  <= '0;
      r_cap_bank  <= 1'b0;
      err_sync    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      r_col <= w_col_after;
      if (w_stb_rise) begin
        r_col      <= '0;
        r_last_row <= w_row;
        if (w_stb_bad)
          r_plane <= '0;
        else if (w_row_jump)
          r_plane <= c_PW'(1);
        else if (r_plane != c_LASTP)
          r_plane <= r_plane + c_PW'(1);
        else
          r_plane <= '0;
      end
      if (w_handoff)
        r_cap_bank <= ~r_cap_bank;
      // set has priority over clear
      if (w_clk_err | w_stb_bad | w_row_jump)
        err_sync <= 1'b1;
      else if (err_clr)
        err_sync <= 1'b0;
      if (w_overrun)
        err_overrun <= 1'b1;
      else if (err_clr)
        err_overrun <= 1'b0;
    end
  end

  // ---------------- line staging and bit-plane accumulator ----------------
  // Each plane is shifted into a one-line staging buffer and committed to
  // the accumulator at the strobe, once the destination plane is known.
  logic [5:0]             r_line     [c_N];
  logic [5:0]             w_line_now [c_N];
  logic [COLOR_DEPTH-1:0] r_acc      [2][c_N][6];

  always_comb begin
    for (int x = 0; x < c_N; x++)
      w_line_now[x] = r_line[x];
    if (w_clk_wr)
      w_line_now[r_col[c_XW-1:0]] = r_sync2[5:0];
  end

  always_ff @(posedge ctrl_clk) begin
    if (w_clk_wr)
      r_line[r_col[c_XW-1:0]] <= r_sync2[5:0];
    if (w_stb_ok)
      for (int x = 0; x < c_N; x++)
        for (int ch = 0; ch < 6; ch++)
          r_acc[r_cap_bank][x][ch][w_commit_plane] <= w_line_now[x][ch];
  end

  // ---------------- flush FSM ----------------
  logic [c_IW-1:0]        r_idx;
  logic                   r_flush_bank;
  logic [4:0]             r_flush_row;
  logic                   w_load, w_done, w_half;
  logic [c_XW-1:0]        w_x;
  logic [COLOR_DEPTH-1:0] w_pr, w_pg, w_pb;

  always_ff @(posedge ctrl_clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (w_handoff) w_state_nxt = S_WRITE;
      S_WRITE: begin
        // advance when nothing is presented or the presented beat is taken
        w_load = ~ctrl_en | ctrl_ready;
        if (w_load && (r_idx == c_BEATS)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_half = r_idx[c_XW];
  assign w_x    = r_idx[c_XW-1:0];
  assign w_pr   = w_half ? r_acc[r_flush_bank][w_x][3] : r_acc[r_flush_bank][w_x][0];
  assign w_pg   = w_half ? r_acc[r_flush_bank][w_x][4] : r_acc[r_flush_bank][w_x][1];
  assign w_pb   = w_half ? r_acc[r_flush_bank][w_x][5] : r_acc[r_flush_bank][w_x][2];

  always_ff @(posedge ctrl_clk or negedge resetn) begin
    if (!resetn) begin
      r_idx        <= '0;
      r_flush_bank <= 1'b0;
      r_flush_row  <= '0;
      ctrl_en      <= 1'b0;
      ctrl_wr      <= '0;
      ctrl_addr    <= '0;
      ctrl_wdat    <= '0;
    end else begin
      if (w_handoff) begin
        r_idx        <= '0;
        r_flush_bank <= r_cap_bank;
        r_flush_row  <= w_row;
      end
      if (w_load) begin
        if (w_done) begin
          ctrl_en <= 1'b0;
          ctrl_wr <= '0;
        end else begin
          ctrl_en   <= 1'b1;
          ctrl_wr   <= 4'b0111;
          // bottom half lives 32 rows below: row bit 5 is the half select
          ctrl_addr <= 16'({w_half, r_flush_row, w_x});
          ctrl_wdat <= {8'(w_pr), 8'(w_pg), 8'(w_pb)};
          r_idx     <= r_idx + c_IW'(1);
        end
      end
    end
  end

`ifdef HUB75_CAPTURE_STATS_EN
  logic [1:0] w_err_events;
  assign w_err_events = 2'(w_clk_err) + 2'(w_stb_bad | w_row_jump | w_overrun);

  always_ff @(posedge ctrl_clk or negedge resetn) begin
    if (!resetn) begin
      stat_rows <= '0;
      stat_errs <= '0;
    end else begin
      if (w_done)
        stat_rows <= stat_rows + 16'd1;
      if (err_clr)
        stat_errs <= 16'(w_err_events);
      else
        stat_errs <= stat_errs + 16'(w_err_events);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hub75_capture.sv
`default_nettype none

module tb_hub75_capture;

  logic        ctrl_clk = 1'b0;
  logic        resetn   = 1'b0;
  logic        hub_r0 = 0, hub_g0 = 0, hub_b0 = 0, hub_r1 = 0, hub_g1 = 0, hub_b1 = 0;
  logic        hub_a = 0, hub_b = 0, hub_c = 0, hub_d = 0, hub_e = 0;
  logic        hub_clk = 0, hub_stb = 0;
  logic        ctrl_ready = 1'b1;
  logic        err_clr = 1'b0;
  logic        ctrl_en;
  logic [3:0]  ctrl_wr;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic        err_sync, err_overrun;
`ifdef HUB75_CAPTURE_STATS_EN
  logic [15:0] stat_rows, stat_errs;
`endif

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;   // 0: always ready, 1: toggle every cycle, 2: never ready

  logic [15:0] q_addr[$];
  logic [23:0] q_dat[$];
  logic [3:0]  q_wr[$];
  int          stall_bad  = 0;
  int          stall_seen = 0;

  hub75_capture dut (
    .ctrl_clk(ctrl_clk), .resetn(resetn),
    .hub_r0(hub_r0), .hub_g0(hub_g0), .hub_b0(hub_b0),
    .hub_r1(hub_r1), .hub_g1(hub_g1), .hub_b1(hub_b1),
    .hub_a(hub_a), .hub_b(hub_b), .hub_c(hub_c), .hub_d(hub_d), .hub_e(hub_e),
    .hub_clk(hub_clk), .hub_stb(hub_stb),
    .ctrl_ready(ctrl_ready), .err_clr(err_clr),
    .ctrl_en(ctrl_en), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr), .ctrl_wdat(ctrl_wdat),
    .err_sync(err_sync), .err_overrun(err_overrun)
`ifdef HUB75_CAPTURE_STATS_EN
    , .stat_rows(stat_rows), .stat_errs(stat_errs)
`endif
  );

  always #5 ctrl_clk = ~ctrl_clk;

  // ready pattern generator
  initial begin
    forever begin
      @(posedge ctrl_clk); #1;
      case (rdy_mode)
        0:       ctrl_ready = 1'b1;
        1:       ctrl_ready = ~ctrl_ready;
        default: ctrl_ready = 1'b0;
      endcase
    end
  end

  // write monitor: records accepted beats and checks hold-stability on stalls
  initial begin
    logic        prev_stall;
    logic [15:0] prev_addr;
    logic [23:0] prev_dat;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_dat   = '0;
    forever begin
      @(negedge ctrl_clk);
      if (prev_stall && (ctrl_en !== 1'b1 || ctrl_addr !== prev_addr || ctrl_wdat !== prev_dat))
        stall_bad++;
      if (ctrl_en === 1'b1 && ctrl_ready === 1'b0)
        stall_seen++;
      if (ctrl_en === 1'b1 && ctrl_ready === 1'b1) begin
        q_addr.push_back(ctrl_addr);
        q_dat.push_back(ctrl_wdat);
        q_wr.push_back(ctrl_wr);
      end
      prev_stall = (ctrl_en === 1'b1) && (ctrl_ready === 1'b0);
      prev_addr  = ctrl_addr;
      prev_dat   = ctrl_wdat;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // pattern 0: R=55 G=2A B=7F everywhere; pattern 1: x-dependent, halves differ
  function automatic logic [23:0] exp_pix(input int pat, input int x, input bit half);
    logic [6:0] r, g, b, xv;
    xv = x[6:0];
    if (pat == 0) begin
      r = 7'h55; g = 7'h2A; b = 7'h7F;
    end else if (!half) begin
      r = xv; g = 7'h7F - xv; b = 7'h11;
    end else begin
      r = 7'h40 | xv; g = xv ^ 7'h2A; b = 7'h33;
    end
    return {1'b0, r, 1'b0, g, 1'b0, b};
  endfunction

  function automatic logic [15:0] exp_addr(input int row, input int i);
    int r6;
    r6 = (i >= 64) ? row + 32 : row;
    return 16'(r6 * 64 + (i % 64));
  endfunction

  function automatic logic [23:0] exp_dat(input int pat, input int i);
    return exp_pix(pat, i % 64, i >= 64);
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge ctrl_clk);
  endtask

  task automatic send_plane(input int row, input int pat, input int plane, input int npx);
    logic [23:0] top, bot;
    logic [4:0]  rv;
    rv = row[4:0];
    {hub_e, hub_d, hub_c, hub_b, hub_a} = rv;
    for (int px = 0; px < npx; px++) begin
      top = exp_pix(pat, px, 1'b0);
      bot = exp_pix(pat, px, 1'b1);
      @(negedge ctrl_clk);
      hub_r0 = top[16 + plane]; hub_g0 = top[8 + plane]; hub_b0 = top[plane];
      hub_r1 = bot[16 + plane]; hub_g1 = bot[8 + plane]; hub_b1 = bot[plane];
      wait_cycles(3);
      hub_clk = 1'b1;
      wait_cycles(3);
      hub_clk = 1'b0;
    end
    wait_cycles(3);
    hub_stb = 1'b1;
    wait_cycles(3);
    hub_stb = 1'b0;
    wait_cycles(3);
  endtask

  task automatic send_row(input int row, input int pat);
    for (int p = 0; p < 7; p++)
      send_plane(row, pat, p, 64);
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (q_addr.size() < n && k < 3000) begin
      @(posedge ctrl_clk);
      k++;
    end
    wait_cycles(50);
  endtask

  task automatic pulse_err_clr();
    @(negedge ctrl_clk);
    err_clr = 1'b1;
    @(negedge ctrl_clk);
    err_clr = 1'b0;
    @(negedge ctrl_clk);
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_dat.delete();
    q_wr.delete();
    stall_bad  = 0;
    stall_seen = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    wait_cycles(4);
    checks++;
    if (ctrl_en !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl_en: got %b expected 0", ctrl_en);
    end
    checks++;
    if ({ctrl_wr, ctrl_addr, ctrl_wdat} !== 44'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {ctrl_wr, ctrl_addr, ctrl_wdat});
    end
    checks++;
    if ({err_sync, err_overrun} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b expected 00", {err_sync, err_overrun});
    end
    resetn = 1'b1;
    wait_cycles(4);
  endtask

  task automatic test_basic();
    int bad;
    clear_log();
    rdy_mode = 0;
    send_row(5, 0);
    wait_writes(128);
    checks++;
    if (q_addr.size() != 128) begin
      errors++; $display("FAIL basic_count: got %0d expected 128", q_addr.size());
    end
    bad = 0;
    for (int i = 0; i < q_addr.size() && i < 128; i++)
      if (q_addr[i] !== exp_addr(5, i) || q_dat[i] !== 24'h552A7F || q_wr[i] !== 4'b0111) begin
        if (bad == 0)
          $display("FAIL basic_beat%0d: got addr %h dat %h wr %b expected addr %h dat 552a7f wr 0111",
                   i, q_addr[i], q_dat[i], q_wr[i], exp_addr(5, i));
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL basic_beats: got %0d bad beats expected 0", bad);
    end
    checks++;
    if ({err_sync, err_overrun} !== 2'b00) begin
      errors++; $display("FAIL basic_flags: got %b expected 00", {err_sync, err_overrun});
    end
  endtask

  task automatic test_stall();
    int bad;
    clear_log();
    rdy_mode = 1;
    send_row(5, 0);
    wait_writes(128);
    rdy_mode = 0;
    checks++;
    if (q_addr.size() != 128) begin
      errors++; $display("FAIL stall_count: got %0d expected 128", q_addr.size());
    end
    bad = 0;
    for (int i = 0; i < q_addr.size() && i < 128; i++)
      if (q_addr[i] !== exp_addr(5, i) || q_dat[i] !== 24'h552A7F) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_beats: got %0d bad beats expected 0", bad);
    end
    checks++;
    if (stall_seen == 0) begin
      errors++; $display("FAIL stall_seen: got 0 stalled cycles expected nonzero");
    end
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL stall_hold: got %0d unstable stall cycles expected 0", stall_bad);
    end
  endtask

  task automatic test_sync_err();
    int bad;
    clear_log();
    send_plane(6, 0, 0, 63);
    wait_cycles(20);
    checks++;
    if (err_sync !== 1'b1) begin
      errors++; $display("FAIL syncerr_flag: got %b expected 1", err_sync);
    end
    checks++;
    if (q_addr.size() != 0) begin
      errors++; $display("FAIL syncerr_nowrite: got %0d writes expected 0", q_addr.size());
    end
    pulse_err_clr();
    checks++;
    if (err_sync !== 1'b0) begin
      errors++; $display("FAIL syncerr_clr: got %b expected 0", err_sync);
    end
    send_row(6, 1);
    wait_writes(128);
    checks++;
    if (q_addr.size() != 128) begin
      errors++; $display("FAIL syncerr_recover_count: got %0d expected 128", q_addr.size());
    end
    bad = 0;
    for (int i = 0; i < q_addr.size() && i < 128; i++)
      if (q_addr[i] !== exp_addr(6, i) || q_dat[i] !== exp_dat(1, i)) begin
        if (bad == 0)
          $display("FAIL syncerr_beat%0d: got addr %h dat %h expected addr %h dat %h",
                   i, q_addr[i], q_dat[i], exp_addr(6, i), exp_dat(1, i));
        bad++;
      end
    checks++;
    if (bad != 0 || err_sync !== 1'b0) begin
      errors++; $display("FAIL syncerr_recover: got %0d bad beats err_sync %b expected 0 and 0", bad, err_sync);
    end
  endtask

  task automatic test_overrun();
    int bad;
    clear_log();
    rdy_mode = 2;
    send_row(3, 1);
    send_row(4, 0);
    wait_cycles(10);
    checks++;
    if (err_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_flag: got %b expected 1", err_overrun);
    end
    checks++;
    if (q_addr.size() != 0) begin
      errors++; $display("FAIL overrun_stalled: got %0d writes expected 0", q_addr.size());
    end
    rdy_mode = 0;
    wait_writes(128);
    wait_cycles(200);
    checks++;
    if (q_addr.size() != 128) begin
      errors++; $display("FAIL overrun_count: got %0d expected 128", q_addr.size());
    end
    bad = 0;
    for (int i = 0; i < q_addr.size() && i < 128; i++)
      if (q_addr[i] !== exp_addr(3, i) || q_dat[i] !== exp_dat(1, i)) begin
        if (bad == 0)
          $display("FAIL overrun_beat%0d: got addr %h dat %h expected addr %h dat %h",
                   i, q_addr[i], q_dat[i], exp_addr(3, i), exp_dat(1, i));
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL overrun_beats: got %0d bad beats expected 0", bad);
    end
    pulse_err_clr();
    checks++;
    if ({err_sync, err_overrun} !== 2'b00) begin
      errors++; $display("FAIL overrun_clr: got %b expected 00", {err_sync, err_overrun});
    end
  endtask

  task automatic test_row_jump();
    int bad;
    clear_log();
    for (int p = 0; p < 4; p++)
      send_plane(2, 0, p, 64);
    send_row(9, 1);
    wait_writes(128);
    checks++;
    if (err_sync !== 1'b1) begin
      errors++; $display("FAIL jump_flag: got %b expected 1", err_sync);
    end
    checks++;
    if (q_addr.size() != 128) begin
      errors++; $display("FAIL jump_count: got %0d expected 128", q_addr.size());
    end
    bad = 0;
    for (int i = 0; i < q_addr.size() && i < 128; i++)
      if (q_addr[i] !== exp_addr(9, i) || q_dat[i] !== exp_dat(1, i)) begin
        if (bad == 0)
          $display("FAIL jump_beat%0d: got addr %h dat %h expected addr %h dat %h",
                   i, q_addr[i], q_dat[i], exp_addr(9, i), exp_dat(1, i));
        bad++;
      end
    checks++;
    if (bad != 0 || err_overrun !== 1'b0) begin
      errors++; $display("FAIL jump_beats: got %0d bad beats err_overrun %b expected 0 and 0", bad, err_overrun);
    end
    pulse_err_clr();
  endtask

  task automatic test_reset_midflush();
    int bad, k;
    clear_log();
    send_row(10, 0);
    k = 0;
    while (q_addr.size() < 40 && k < 2000) begin
      @(posedge ctrl_clk); #1;
      k++;
    end
    checks++;
    if (q_addr.size() != 40) begin
      errors++; $display("FAIL midflush_reach40: got %0d beats expected 40", q_addr.size());
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (ctrl_en !== 1'b0) begin
      errors++; $display("FAIL midflush_en: got %b expected 0", ctrl_en);
    end
    wait_cycles(3);
    resetn = 1'b1;
    wait_cycles(3);
    clear_log();
    send_row(11, 1);
    wait_writes(128);
    checks++;
    if (q_addr.size() != 128) begin
      errors++; $display("FAIL midflush_count: got %0d expected 128", q_addr.size());
    end
    bad = 0;
    for (int i = 0; i < q_addr.size() && i < 128; i++)
      if (q_addr[i] !== exp_addr(11, i) || q_dat[i] !== exp_dat(1, i)) begin
        if (bad == 0)
          $display("FAIL midflush_beat%0d: got addr %h dat %h expected addr %h dat %h",
                   i, q_addr[i], q_dat[i], exp_addr(11, i), exp_dat(1, i));
        bad++;
      end
    checks++;
    if (bad != 0 || {err_sync, err_overrun} !== 2'b00) begin
      errors++; $display("FAIL midflush_beats: got %0d bad beats flags %b expected 0 and 00",
                         bad, {err_sync, err_overrun});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_sync_err();
    test_overrun();
    test_row_jump();
    test_reset_midflush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
